// File: rtl/hw_call_stack.sv
// hw_call_stack: a LIFO hardware call stack with registered top-of-stack output.
//
// Parameters
//   WIDTH    : bit width of each stack entry
//   DEPTH    : number of entries (power of two, >= 2)
//   OVF_MODE : 0 = a push while full wraps and overwrites the oldest entry,
//              1 = a push while full is dropped
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   push      in   push data_in this cycle
//   pop       in   pop the top entry this cycle (push+pop = replace top)
//   clr_err   in   clear sticky overflow/underflow
//   data_in   in   value to push
//   data_out  out  registered top-of-stack value, 0 when empty
//   count     out  number of valid entries, 0..DEPTH
//   empty     out  count == 0
//   full      out  count == DEPTH
//   overflow  out  sticky, set by a push while full
//   underflow out  sticky, set by a pop while empty
module hw_call_stack #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int OVF_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr_err,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic             is_empty;
  logic             is_full;
  logic [AW-1:0]    below_top_addr;

  assign is_empty       = (count_q == '0);
  assign is_full        = (count_q == CW'(DEPTH));
  // Entry just below the current top; it becomes the new top after a pop.
  assign below_top_addr = sp_q - AW'(2);

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = sp_q;

    if (push && pop && !is_empty) begin
      // Replace the top entry in place; output bypasses the memory.
      mem_we     = 1'b1;
      mem_waddr  = sp_q - AW'(1);
      data_out_d = data_in;
    end else if (push) begin
      if (!is_full) begin
        mem_we     = 1'b1;
        sp_d       = sp_q + AW'(1);
        count_d    = count_q + CW'(1);
        data_out_d = data_in;
      end else begin
        overflow_d = 1'b1;
        if (OVF_MODE == 0) begin
          // Slot at sp holds the oldest entry when full; overwrite it.
          mem_we     = 1'b1;
          sp_d       = sp_q + AW'(1);
          data_out_d = data_in;
        end
      end
    end else if (pop) begin
      if (!is_empty) begin
        sp_d       = sp_q - AW'(1);
        count_d    = count_q - CW'(1);
        data_out_d = (count_q == CW'(1)) ? '0 : mem_q[below_top_addr];
      end else begin
        underflow_d = 1'b1;
      end
    end

    // Clearing wins over a same-cycle set.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q        <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; stale entries are unreachable until rewritten.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign count     = count_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
